// File: rtl/dps_phase_ctrl.sv
// DCM dynamic phase-shift sequencer: walks the fine phase one PSEN/PSDONE step at a time,
// then updates the quadrant select (hcycle/qcycle) once the fine phase is final.
module dps_phase_ctrl #(
  parameter int FINE_BITS      = 6,
  parameter int PSDONE_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [FINE_BITS+1:0] phase_req,
  input  logic                 update,
  input  logic                 dps_locked,
  input  logic                 dps_psdone,
  output logic                 dps_psen,
  output logic                 dps_psincdec,
  output logic                 hcycle,
  output logic                 qcycle,
  output logic [FINE_BITS-1:0] fine_now,
  output logic                 busy,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    COMPARE   = 3'd2,
    STEP      = 3'd3,
    WAIT_DONE = 3'd4,
    QUAD      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [FINE_BITS-1:0] FINE_ONE    = FINE_BITS'(1);
  localparam logic [8:0]           TIMEOUT_LIM = 9'(PSDONE_TIMEOUT);

  state_t               state_r, state_s;
  logic [1:0]           target_q_r, target_q_s;
  logic [FINE_BITS-1:0] target_f_r, target_f_s;
  logic [FINE_BITS-1:0] fine_s;
  logic [7:0]           cnt_r, cnt_s;
  logic                 psen_s, incdec_s, hcycle_s, qcycle_s, busy_s, error_s;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s    = state_r;
    target_q_s = target_q_r;
    target_f_s = target_f_r;
    fine_s     = fine_now;
    cnt_s      = cnt_r;
    incdec_s   = dps_psincdec;
    hcycle_s   = hcycle;
    qcycle_s   = qcycle;
    error_s    = error;
    case (state_r)
      IDLE: begin
        if (update) begin
          target_q_s = phase_req[FINE_BITS+1:FINE_BITS];
          target_f_s = phase_req[FINE_BITS-1:0];
          state_s    = WAIT_LOCK;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_LOCK: begin
        if (dps_locked) begin
          state_s = COMPARE;
        end else begin
          state_s = WAIT_LOCK;
        end
      end
      COMPARE: begin
        if (fine_now == target_f_r) begin
          state_s = QUAD;
        end else begin
          incdec_s = (target_f_r > fine_now);
          state_s  = STEP;
        end
      end
      STEP: begin
        cnt_s   = 8'd0;
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Lock loss resets the DCM phase to 0, so the tracked position follows.
        if (!dps_locked) begin
          fine_s  = {FINE_BITS{1'b0}};
          error_s = 1'b1;
          state_s = ERROR;
        end else if (dps_psdone) begin
          if (dps_psincdec) begin
            fine_s = fine_now + FINE_ONE;
          end else begin
            fine_s = fine_now - FINE_ONE;
          end
          state_s = COMPARE;
        end else if (({1'b0, cnt_r} + 9'd1) == TIMEOUT_LIM) begin
          error_s = 1'b1;
          state_s = ERROR;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      QUAD: begin
        hcycle_s = target_q_r[1];
        qcycle_s = target_q_r[0];
        state_s  = IDLE;
      end
      ERROR: begin
        if (update) begin
          error_s    = 1'b0;
          target_q_s = phase_req[FINE_BITS+1:FINE_BITS];
          target_f_s = phase_req[FINE_BITS-1:0];
          state_s    = WAIT_LOCK;
        end else begin
          state_s = ERROR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    psen_s = (state_s == STEP);
    busy_s = (state_s != IDLE) && (state_s != ERROR);
  end

  // State, target, counter and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      target_q_r   <= 2'b00;
      target_f_r   <= {FINE_BITS{1'b0}};
      cnt_r        <= 8'd0;
      fine_now     <= {FINE_BITS{1'b0}};
      dps_psen     <= 1'b0;
      dps_psincdec <= 1'b0;
      hcycle       <= 1'b0;
      qcycle       <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_r      <= state_s;
      target_q_r   <= target_q_s;
      target_f_r   <= target_f_s;
      cnt_r        <= cnt_s;
      fine_now     <= fine_s;
      dps_psen     <= psen_s;
      dps_psincdec <= incdec_s;
      hcycle       <= hcycle_s;
      qcycle       <= qcycle_s;
      busy         <= busy_s;
      error        <= error_s;
    end
  end

endmodule

// File: tb/tb_dps_phase_ctrl.sv
// Directed self-checking bench for dps_phase_ctrl with a PSDONE responder folded into the run task.
module tb_dps_phase_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] phase_req = 8'd0;
  logic       update = 1'b0;
  logic       dps_locked = 1'b1;
  logic       dps_psdone = 1'b0;
  logic       dps_psen, dps_psincdec, hcycle, qcycle, busy, error;
  logic [5:0] fine_now;

  int tests = 0;
  int fails = 0;

  dps_phase_ctrl #(.FINE_BITS(6), .PSDONE_TIMEOUT(255)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .phase_req   (phase_req),
    .update      (update),
    .dps_locked  (dps_locked),
    .dps_psdone  (dps_psdone),
    .dps_psen    (dps_psen),
    .dps_psincdec(dps_psincdec),
    .hcycle      (hcycle),
    .qcycle      (qcycle),
    .fine_now    (fine_now),
    .busy        (busy),
    .error       (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [7:0] req);
    phase_req = req;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  // Runs until busy falls, answering each psen with psdone sampled two edges later.
  task automatic run(input int max_cyc, input logic exp_dir, input int bogus_at,
                     input logic [7:0] bogus_req, output int pulses,
                     output logic dir_bad, output logic quad_early);
    int   cd;
    logic seen, h0, q0;
    pulses = 0; cd = -1; seen = 1'b0; dir_bad = 1'b0; quad_early = 1'b0;
    h0 = hcycle; q0 = qcycle;
    for (int i = 0; i < max_cyc && busy; i++) begin
      tick();
      dps_psdone = 1'b0;
      update = 1'b0;
      if (cd > 0) cd--;
      if (cd == 0) begin
        dps_psdone = 1'b1;
        cd = -1;
      end
      if (dps_psen) begin
        pulses++;
        cd = 1;
        seen = 1'b1;
      end
      if (seen && dps_psincdec !== exp_dir) dir_bad = 1'b1;
      if (busy && (hcycle !== h0 || qcycle !== q0)) quad_early = 1'b1;
      if (i == bogus_at) begin
        phase_req = bogus_req;
        update = 1'b1;
      end
    end
    dps_psdone = 1'b0;
    update = 1'b0;
  endtask

  task automatic wait_psen(output logic found);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = dps_psen;
    end
  endtask

  initial begin
    int   p;
    logic db, qe, found;

    // Reset state
    tick(); tick();
    check("rst_psen", 32'(dps_psen), 32'd0);
    check("rst_incdec", 32'(dps_psincdec), 32'd0);
    check("rst_hq", 32'({hcycle, qcycle}), 32'd0);
    check("rst_fine", 32'(fine_now), 32'd0);
    check("rst_busy_err", 32'({busy, error}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Quadrant only, no fine change: busy for 3 clocks, hcycle at 3rd edge
    request({2'b10, 6'd0});
    check("t1_e0_busy", 32'(busy), 32'd1);
    tick();
    check("t1_e1_busy", 32'(busy), 32'd1);
    check("t1_e1_psen", 32'(dps_psen), 32'd0);
    tick();
    check("t1_e2_busy_h", 32'({busy, hcycle}), 32'b10);
    check("t1_e2_psen", 32'(dps_psen), 32'd0);
    tick();
    check("t1_e3_busy", 32'(busy), 32'd0);
    check("t1_e3_hq", 32'({hcycle, qcycle}), 32'b10);
    check("t1_fine", 32'(fine_now), 32'd0);

    // Step up 0 -> 5
    request({2'b01, 6'd5});
    run(100, 1'b1, -1, 8'd0, p, db, qe);
    check("t2_pulses", 32'(p), 32'd5);
    check("t2_dir", 32'(db), 32'd0);
    check("t2_quad_early", 32'(qe), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_fine", 32'(fine_now), 32'd5);
    check("t2_hq", 32'({hcycle, qcycle}), 32'b01);

    // Step down 5 -> 2
    request({2'b11, 6'd2});
    run(100, 1'b0, -1, 8'd0, p, db, qe);
    check("t3_pulses", 32'(p), 32'd3);
    check("t3_dir", 32'(db), 32'd0);
    check("t3_quad_early", 32'(qe), 32'd0);
    check("t3_fine", 32'(fine_now), 32'd2);
    check("t3_hq", 32'({hcycle, qcycle}), 32'b11);

    // PSDONE timeout after 255 WAIT_DONE clocks
    request({2'b00, 6'd3});
    wait_psen(found);
    check("t4_psen_seen", 32'(found), 32'd1);
    repeat (255) tick();
    check("t4_pre_err_busy", 32'({error, busy}), 32'b01);
    tick();
    check("t4_err_busy", 32'({error, busy}), 32'b10);
    check("t4_hq_hold", 32'({hcycle, qcycle}), 32'b11);
    check("t4_fine_hold", 32'(fine_now), 32'd2);
    request({2'b11, 6'd2});
    check("t4_clear_err", 32'({error, busy}), 32'b01);
    repeat (3) tick();
    check("t4_done", 32'({error, busy}), 32'b00);

    // Lock loss during WAIT_DONE
    request({2'b00, 6'd4});
    wait_psen(found);
    check("t5_psen_seen", 32'(found), 32'd1);
    dps_locked = 1'b0;
    tick();
    check("t5_wait_no_err", 32'(error), 32'd0);
    tick();
    check("t5_err_busy", 32'({error, busy}), 32'b10);
    check("t5_fine_zero", 32'(fine_now), 32'd0);
    check("t5_hq_hold", 32'({hcycle, qcycle}), 32'b11);
    request({2'b10, 6'd1});
    check("t5_waitlock_busy", 32'({error, busy}), 32'b01);
    repeat (5) tick();
    check("t5_still_waiting", 32'({busy, dps_psen}), 32'b10);
    dps_locked = 1'b1;
    run(100, 1'b1, -1, 8'd0, p, db, qe);
    check("t5_pulses", 32'(p), 32'd1);
    check("t5_fine", 32'(fine_now), 32'd1);
    check("t5_hq", 32'({hcycle, qcycle}), 32'b10);
    check("t5_busy", 32'(busy), 32'd0);

    // Update while busy is ignored
    request({2'b01, 6'd3});
    run(100, 1'b1, 2, {2'b10, 6'd0}, p, db, qe);
    check("t6_pulses", 32'(p), 32'd2);
    check("t6_fine", 32'(fine_now), 32'd3);
    check("t6_hq", 32'({hcycle, qcycle}), 32'b01);
    check("t6_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-step
    request({2'b11, 6'd10});
    wait_psen(found);
    check("t7_psen_seen", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t7_psen_incdec", 32'({dps_psen, dps_psincdec}), 32'd0);
    check("t7_fine", 32'(fine_now), 32'd0);
    check("t7_hq", 32'({hcycle, qcycle}), 32'd0);
    check("t7_busy_err", 32'({busy, error}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
